// File: rtl/jtdsp16_sio_fifo_if.sv
// jtdsp16_sio_fifo_if: CPU register bus plus serial pin group of the DSP16 SIO block.
// Latency: none, this is a bundle of wires.
// Backpressure: none; obe/ovf tell the CPU whether an sdx write was queued or dropped.
// Modports: master = CPU / pin driver side, slave = the SIO block.
interface jtdsp16_sio_fifo_if;
  logic [15:0] wr_data;
  logic        wr;
  logic        rd;
  logic [2:0]  r_field;
  logic [15:0] r_sio;
  logic        ovf;
  logic        ock;
  logic        sio_do;
  logic        sadd;
  logic        old;
  logic        ose;
  logic        obe;
  logic        ick;
  logic        ild;
  logic        sio_di;
  logic        ibf;

  modport master (
    output wr_data, wr, rd, r_field, ick, ild, sio_di,
    input  r_sio, ovf, ock, sio_do, sadd, old, ose, obe, ibf
  );

  modport slave (
    input  wr_data, wr, rd, r_field, ick, ild, sio_di,
    output r_sio, ovf, ock, sio_do, sadd, old, ose, obe, ibf
  );
endinterface

// File: rtl/jtdsp16_sio_fifo.sv
// jtdsp16_sio_fifo: DSP16 serial I/O with a DEPTH-word output FIFO and an optional input shifter.
// Latency: an sdx word pops one cen cycle after it is written to an idle block; old falls CLKDIV/2 cen cycles later.
// Backpressure: obe=0 when the FIFO is full; further sdx writes are dropped and set the sticky ovf.
// Ports: clk, rst (sync, active high), cen (clock enable), bus (jtdsp16_sio_fifo_if.slave).
// Optional feature: define JTDSP16_SIO_INPUT_EN to build the serial input path (ick/ild/sio_di -> ibuf/ibf).
module jtdsp16_sio_fifo #(
  parameter int CLKDIV = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  jtdsp16_sio_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(CLKDIV);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(CLKDIV/2 - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLKDIV/2);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;

  logic [9:0]    sioc;
  logic [7:0]    srta;
  logic          ovf_q;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic [DW-1:0] div;
  logic [4:0]    bitcnt;
  logic [15:0]   sr;
  logic [7:0]    sa;
  logic          wl8, msb, first, old_q;
  logic          wr_sioc, wr_srta, wr_sdx;
  logic          full, empty, push, pop, drop, rise, done;
  logic [23:0]   head;
  logic [15:0]   ibuf_rd;

  assign wr_sioc = cen & bus.wr & (bus.r_field == 3'd0);
  assign wr_srta = cen & bus.wr & (bus.r_field == 3'd1);
  assign wr_sdx  = cen & bus.wr & (bus.r_field == 3'd2);
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push    = wr_sdx & (~full | pop);
  assign drop    = wr_sdx & full & ~pop;
  assign head    = mem[rd_ptr];

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    rise     = 1'b0;
    done     = 1'b0;
    if (cen) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            pop      = 1'b1;
            state_nx = SHIFT;
          end
        end
        SHIFT: begin
          if (bitcnt == 5'd0) begin
            // Word finished: chain the next one with no gap, or go idle.
            done = 1'b1;
            if (!empty) pop = 1'b1;
            else        state_nx = IDLE;
          end else if (div == DIV_PRE) begin
            rise = 1'b1;  // ock goes high on this edge
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.wr_data, srta};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sioc   <= '0;
      srta   <= '0;
      ovf_q  <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      div    <= '0;
      bitcnt <= '0;
      sr     <= '0;
      sa     <= '0;
      wl8    <= 1'b0;
      msb    <= 1'b0;
      first  <= 1'b0;
      old_q  <= 1'b1;
    end else begin
      if (wr_sioc) begin
        sioc  <= bus.wr_data[9:0];
        ovf_q <= 1'b0;
      end
      if (wr_srta) srta  <= bus.wr_data[7:0];
      if (drop)    ovf_q <= 1'b1;
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (cen) begin
        if (pop || state_nx == IDLE) div <= '0;
        else if (div == DIV_LAST)    div <= '0;
        else                         div <= div + 1'b1;

        if (pop) begin
          // Word length and order are latched here so sioc writes mid-word are harmless.
          sr     <= sioc[1] ? {8'd0, head[15:8]} : head[23:8];
          sa     <= head[7:0];
          bitcnt <= sioc[1] ? 5'd8 : 5'd16;
          wl8    <= sioc[1];
          msb    <= sioc[6];
          first  <= 1'b1;
        end else if (rise) begin
          if (first) begin
            // Load edge: old falls, data does not move.
            first <= 1'b0;
            old_q <= 1'b0;
          end else begin
            if (msb) begin
              sr <= {sr[14:0], 1'b0};
              sa <= {sa[6:0], 1'b0};
            end else begin
              sr <= {1'b0, sr[15:1]};
              sa <= {1'b0, sa[7:1]};
            end
            bitcnt <= bitcnt - 1'b1;
          end
        end else if (done) begin
          old_q <= 1'b1;
        end
      end
    end
  end

  assign bus.ock    = (state == SHIFT) && (div >= DIV_HALF);
  assign bus.sio_do = (state == SHIFT) && (msb ? (wl8 ? sr[7] : sr[15]) : sr[0]);
  assign bus.sadd   = (state == SHIFT) && (msb ? sa[7] : sa[0]);
  assign bus.old    = old_q;
  assign bus.ose    = (state == IDLE) && empty;
  assign bus.obe    = ~full;
  assign bus.ovf    = ovf_q;

`ifdef JTDSP16_SIO_INPUT_EN
  logic        ick_d, irise, xfer, rd_sdx;
  logic [15:0] isr, isr_nx, ibuf;
  logic [4:0]  icnt;
  logic        ibf_q;

  always_comb begin
    rd_sdx = cen & bus.rd & (bus.r_field == 3'd2);
    irise  = cen & bus.ick & ~ick_d & ~bus.ild;
    isr_nx = sioc[6] ? {isr[14:0], bus.sio_di} : {bus.sio_di, isr[15:1]};
    xfer   = irise && (icnt == (sioc[1] ? 5'd7 : 5'd15));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ick_d <= 1'b0;
      isr   <= '0;
      icnt  <= '0;
      ibuf  <= '0;
      ibf_q <= 1'b0;
    end else if (cen) begin
      ick_d <= bus.ick;
      // ild high re-aligns the input word boundary.
      if (bus.ild) icnt <= '0;
      else if (irise) begin
        isr  <= isr_nx;
        icnt <= xfer ? 5'd0 : icnt + 1'b1;
      end
      if (rd_sdx) ibf_q <= 1'b0;
      // An arriving word wins over a read in the same cycle.
      if (xfer) begin
        ibf_q <= 1'b1;
        if (!sioc[1])    ibuf <= isr_nx;
        else if (sioc[6]) ibuf <= {8'd0, isr_nx[7:0]};
        else             ibuf <= {8'd0, isr_nx[15:8]};
      end
    end
  end

  assign bus.ibf = ibf_q;
  assign ibuf_rd = ibuf;
`else
  logic unused_in;
  assign unused_in = ^{bus.ick, bus.ild, bus.sio_di, bus.rd};
  assign bus.ibf   = 1'b0;
  assign ibuf_rd   = '0;
`endif

  always_comb begin
    bus.r_sio = '0;
    case (bus.r_field)
      3'd0:    bus.r_sio = {6'd0, sioc};
      3'd1:    bus.r_sio = {8'd0, srta};
      3'd2:    bus.r_sio = ibuf_rd;
      default: bus.r_sio = '0;
    endcase
  end
endmodule

// File: doc/jtdsp16_sio_fifo.md
JTDSP16_SIO_FIFO -- requirements
Module: jtdsp16_sio_fifo

Interface
REQ-001 SHALL have parameter CLKDIV, default 12, meaning the ock period in cen cycles; it SHALL be even and at least 4.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the output FIFO depth in words; it SHALL be a power of 2 and at least 2.
REQ-003 SHALL have one clock and a synchronous, active-high reset: `clk  in  1  system clock`; `rst  in  1  reset`.
REQ-004 SHALL have the following ports:
  `cen  in  1  clock enable; all state advances only on cen=1`
  `ock  out  1  serial output clock`
  `sio_do  out  1  serial data out`
  `sadd  out  1  serial address bit`
  `old  out  1  output load, active low`
  `ose  out  1  shifter and FIFO both empty`
  `obe  out  1  FIFO has a free slot`
  `ick  in  1  serial input clock`
  `ild  in  1  input load, active low`
  `sio_di  in  1  serial data in`
  `ibf  out  1  input buffer full`
  `wr_data  in  16  CPU write data`
  `wr  in  1  CPU write strobe`
  `rd  in  1  CPU read strobe`
  `r_field  in  3  register select: 0=sioc, 1=srta, 2=sdx`
  `r_sio  out  16  combinational read data`
  `ovf  out  1  sticky FIFO overflow`

Function
REQ-005 A write with r_field=0 SHALL load sioc[9:0] from wr_data[9:0] and clear ovf.
- sioc[1]: 1 = 8-bit word, 0 = 16-bit word.
- sioc[6]: 1 = MSB first, 0 = LSB first.
REQ-006 A write with r_field=1 SHALL load srta[7:0].
REQ-007 A write with r_field=2 SHALL push {wr_data, srta} into the FIFO when obe=1; when the FIFO is full, the word SHALL be dropped and ovf set.
REQ-008 obe SHALL equal (FIFO count < DEPTH) and SHALL fall in the cycle after the push that fills the FIFO.
REQ-009 The shifter SHALL have two states, IDLE and SHIFT. In IDLE with the FIFO non-empty, it SHALL pop the head in that cen cycle and enter SHIFT:
- the bit counter is set to WL (8 or 16);
- the divider is cleared.
REQ-010 The divider SHALL count 0..CLKDIV-1 and wrap.
- ock=1 while the divider is at or above CLKDIV/2 and the state is SHIFT.
- ock=0 otherwise.
REQ-011 On the first ock rising edge after a pop, old SHALL go 0 and no shift SHALL occur.
REQ-012 On each later ock rising edge, the shifter SHALL advance one bit and the bit counter SHALL decrement.
- sio_do is data bit 15 (or bit 7 in 8-bit mode) when MSB first, and bit 0 when LSB first.
- sadd is the srta bit shifted in the same order.
REQ-013 When the bit counter reaches 0, the block SHALL take one of two paths:
- If the FIFO is non-empty, it SHALL pop the next word in the same cycle with no gap, keeping old=0 (back-to-back frame).
- Otherwise it SHALL return to IDLE, with old=1 and sio_do=0.
REQ-014 A push and a pop in the same cycle SHALL leave the count unchanged; a push to a full FIFO that pops in the same cycle SHALL be accepted.
REQ-015 ose SHALL equal (state==IDLE and FIFO empty).
REQ-016 Serial input SHALL work as follows:
- Rising edges of ick SHALL be detected with a one-cen-cycle delayed copy.
- While ild=0, each rising edge SHALL shift sio_di into the input register in the order set by sioc[6].
- After WL bits, the word SHALL transfer to ibuf and ibf SHALL be set.
REQ-017 A read with r_field=2 SHALL clear ibf; if a transfer occurs in the same cycle, ibf SHALL stay 1 and ibuf SHALL take the new word.
REQ-018 r_sio SHALL return, by r_field:
- 0: {6'd0, sioc}
- 1: {8'd0, srta}
- 2: ibuf
- others: 0
REQ-019 A write to sioc while in SHIFT SHALL NOT alter the word in flight; the new word length SHALL take effect at the next pop.

Reset
REQ-020 Reset SHALL set all outputs as follows:
- FIFO empty; state IDLE; divider 0.
- ock=0, old=1, sio_do=0, sadd=0, obe=1, ose=1, ibf=0, ovf=0.
- sioc=0, srta=0, ibuf=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame within the same clock edge, regardless of cen.

Configuration
REQ-022 With macro JTDSP16_SIO_INPUT_EN defined, REQ-016 and REQ-017 SHALL be implemented.
REQ-023 Without JTDSP16_SIO_INPUT_EN:
- ick, ild and sio_di SHALL be ignored;
- ibf SHALL be tied to 0;
- r_sio SHALL be 0 for r_field=2.

Verification
REQ-024 Basic frame: cen=1, sioc=0x0040, srta=0x80, write sdx=0xA5C3 -> sio_do shows 1010010111000011 over 16 ock rises after the old-fall rise; sadd=1 on the first bit only; ose returns to 1.
REQ-025 Back-to-back frames and overflow: DEPTH=4, write 5 sdx words back-to-back while idle -> the first pops at once and 4 queue; a 6th write -> dropped, ovf=1; all 5 frames stream with old held 0 throughout; a sioc write clears ovf.
REQ-026 8-bit LSB first: sioc=0x0002, write 0x00F1 -> sio_do 1,0,0,0,1,1,1,1 and then IDLE after 8 bits.
REQ-027 Input with JTDSP16_SIO_INPUT_EN and sioc=0x0040: drive 0x1234 on ick/ild -> ibf=1 and r_sio=0x1234 when r_field=2; rd -> ibf=0.
REQ-028 Reset mid-frame: assert rst after 5 bits -> next cycle old=1, ock=0, obe=1, FIFO empty; a new write afterwards transmits correctly.
